// File: rtl/program_sequencer.sv
`default_nettype none
// ============================================================================
// program_sequencer : fetches 64-bit program words, issues Layer descriptors
//                     and executes INPUT/HALT/JUMP. Optional: SEQ_PERF_CNT_EN
// Revision: 1.0
// ============================================================================
module program_sequencer #(
    parameter int ADDR_W     = 12,
    parameter int WORD_W     = 64,
    parameter int START_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              layer_valid,
    input  logic              layer_ready,
    output logic [10:0]       x_offset,
    output logic [11:0]       w_offset,
    output logic              output_layer,
    output logic [10:0]       y_offset,
    output logic [11:0]       x_length,
    output logic [11:0]       y_length,
    output logic [3:0]        act_mask,
    output logic              input_req,
    input  logic              input_ack,
    output logic              busy,
    output logic              halted,
    output logic              illegal_op,
`ifdef SEQ_PERF_CNT_EN
    output logic [15:0]       layer_count,
    output logic [31:0]       busy_cycles,
`endif
    output logic [ADDR_W-1:0] pc
);

    localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(START_ADDR);
    localparam logic [2:0] OP_INPUT = 3'd1;
    localparam logic [2:0] OP_HALT  = 3'd2;
    localparam logic [2:0] OP_JUMP  = 3'd3;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_FETCH      = 3'd1,
        S_WAIT       = 3'd2,
        S_DECODE     = 3'd3,
        S_ISSUE      = 3'd4,
        S_WAIT_INPUT = 3'd5,
        S_HALTED     = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ctrl_q, ctrl_d;     // word bits [63:48]
    logic [62:0]       fields_q, fields_d; // last Layer descriptor
    logic              illegal_q, illegal_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= START_PC;
            ctrl_q    <= '0;
            fields_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ctrl_q    <= ctrl_d;
            fields_q  <= fields_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ctrl_d      = ctrl_q;
        fields_d    = fields_q;
        illegal_d   = illegal_q;
        mem_rd_en   = 1'b0;
        layer_valid = 1'b0;
        input_req   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = START_PC;
                end
            end
            S_FETCH: begin
                mem_rd_en = 1'b1;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                ctrl_d = mem_rdata[63:48];
                if (!mem_rdata[63]) begin
                    fields_d = mem_rdata[62:0];
                end
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (!ctrl_q[15]) begin
                    // Descriptor is offered in the decode cycle so a ready
                    // engine can accept it without an extra bubble.
                    layer_valid = 1'b1;
                    if (layer_ready) begin
                        pc_d    = pc_q + ADDR_W'(1);
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end else begin
                    case (ctrl_q[14:12])
                        OP_INPUT: state_d = S_WAIT_INPUT;
                        OP_HALT:  state_d = S_HALTED;
                        OP_JUMP: begin
                            pc_d    = ADDR_W'(ctrl_q[11:0]);
                            state_d = S_FETCH;
                        end
                        default: begin
                            illegal_d = 1'b1;
                            state_d   = S_HALTED;
                        end
                    endcase
                end
            end
            S_ISSUE: begin
                layer_valid = 1'b1;
                if (layer_ready) begin
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_FETCH;
                end
            end
            S_WAIT_INPUT: begin
                input_req = 1'b1;
                if (input_ack) begin
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_FETCH;
                end
            end
            S_HALTED: begin
                if (start) begin
                    state_d   = S_FETCH;
                    pc_d      = START_PC;
                    illegal_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mem_addr   = pc_q;
    assign pc         = pc_q;
    assign busy       = (state_q != S_IDLE) && (state_q != S_HALTED);
    assign halted     = (state_q == S_HALTED);
    assign illegal_op = illegal_q;
    assign {x_offset, w_offset, output_layer, y_offset,
            x_length, y_length, act_mask} = fields_q;

`ifdef SEQ_PERF_CNT_EN
    logic [15:0] layer_count_q, layer_count_d;
    logic [31:0] busy_cycles_q, busy_cycles_d;
    logic        start_accept;

    assign start_accept = start && ((state_q == S_IDLE) || (state_q == S_HALTED));

    always_comb begin
        layer_count_d = layer_count_q;
        busy_cycles_d = busy_cycles_q;
        if (start_accept) begin
            layer_count_d = '0;
            busy_cycles_d = '0;
        end else begin
            if (layer_valid && layer_ready && !(&layer_count_q)) begin
                layer_count_d = layer_count_q + 16'd1;
            end
            if (busy && !(&busy_cycles_q)) begin
                busy_cycles_d = busy_cycles_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            layer_count_q <= '0;
            busy_cycles_q <= '0;
        end else begin
            layer_count_q <= layer_count_d;
            busy_cycles_q <= busy_cycles_d;
        end
    end

    assign layer_count = layer_count_q;
    assign busy_cycles = busy_cycles_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_program_sequencer.sv
`default_nettype none
// ============================================================================
// tb_program_sequencer : directed, table-driven bench for program_sequencer
// Revision: 1.0
// ============================================================================
module tb_program_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, layer_ready, input_ack;
    logic        mem_rd_en;
    logic [11:0] mem_addr;
    logic [63:0] mem_rdata = '0;
    logic        layer_valid;
    logic [10:0] x_offset, y_offset;
    logic [11:0] w_offset, x_length, y_length;
    logic        output_layer;
    logic [3:0]  act_mask;
    logic        input_req, busy, halted, illegal_op;
    logic [11:0] pc;
`ifdef SEQ_PERF_CNT_EN
    logic [15:0] layer_count;
    logic [31:0] busy_cycles;
`endif

    program_sequencer dut (
        .clk(clk), .rst(rst), .start(start),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .layer_valid(layer_valid), .layer_ready(layer_ready),
        .x_offset(x_offset), .w_offset(w_offset), .output_layer(output_layer),
        .y_offset(y_offset), .x_length(x_length), .y_length(y_length),
        .act_mask(act_mask), .input_req(input_req), .input_ack(input_ack),
        .busy(busy), .halted(halted), .illegal_op(illegal_op),
`ifdef SEQ_PERF_CNT_EN
        .layer_count(layer_count), .busy_cycles(busy_cycles),
`endif
        .pc(pc)
    );

    always #5 clk = ~clk;

    logic [63:0] mem [0:4095];
    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled mid-cycle
    int          fetch_addr_q[$];
    int          fetch_cyc_q[$];
    int          hs_cyc_q[$];
    int          lv_cnt, busy_cnt;
    logic [62:0] hs_fields;
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_rd_en) begin
                fetch_addr_q.push_back(int'(mem_addr));
                fetch_cyc_q.push_back(cyc);
            end
            if (layer_valid) lv_cnt++;
            if (busy) busy_cnt++;
            if (layer_valid && layer_ready) begin
                hs_cyc_q.push_back(cyc);
                hs_fields = {x_offset, w_offset, output_layer, y_offset,
                             x_length, y_length, act_mask};
            end
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        fetch_addr_q.delete();
        fetch_cyc_q.delete();
        hs_cyc_q.delete();
        lv_cnt    = 0;
        busy_cnt  = 0;
        hs_fields = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; layer_ready = 1'b0; input_ack = 1'b0;
        tick(); tick();
        rst = 1'b0;
        clear_mon();
    endtask

    task automatic pulse_start(output int s);
        start = 1'b1;
        s = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic run_until_halted(input string name, input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            if (halted) break;
            tick();
        end
        if (!halted) check({name, "_halt_timeout"}, 64'(halted), 64'd1);
    endtask

    typedef struct {
        string       name;
        logic [63:0] word;
        int          exp_hs;
        logic [10:0] x;
        logic [11:0] w;
        logic        ol;
        logic [10:0] y;
        logic [11:0] xl;
        logic [11:0] yl;
        logic [3:0]  am;
        logic        exp_ill;
        logic [11:0] exp_pc;
    } vec_t;

    localparam logic [63:0] HALT_W = 64'hA000_0000_0000_0000;

    vec_t vecs[9];

    initial begin : main
        int s;
        int bad;
        int exp_addr[5];
        logic [62:0] held;

        vecs[0] = '{"layerA", 64'h0051_0080_7310_0802, 1, 11'd5, 12'h100, 1'b1, 11'd7, 12'd784, 12'd128, 4'b0010, 1'b0, 12'd1};
        vecs[1] = '{"layerB", 64'h7FFF_FF7F_FFFF_FFFF, 1, 11'h7FF, 12'hFFF, 1'b0, 11'h7FF, 12'hFFF, 12'hFFF, 4'hF, 1'b0, 12'd1};
        vecs[2] = '{"layerC", 64'h0010_0200_3004_0056, 1, 11'd1, 12'd2, 1'b0, 11'd3, 12'd4, 12'd5, 4'd6, 1'b0, 12'd1};
        vecs[3] = '{"layerD", 64'h0000_0080_0000_0000, 1, 11'd0, 12'd0, 1'b1, 11'd0, 12'd0, 12'd0, 4'd0, 1'b0, 12'd1};
        vecs[4] = '{"halt",   64'hA123_4567_89AB_CDEF, 0, 11'd0, 12'd0, 1'b0, 11'd0, 12'd0, 12'd0, 4'd0, 1'b0, 12'd0};
        vecs[5] = '{"op0",    64'h8FFF_0000_0000_0000, 0, 11'd0, 12'd0, 1'b0, 11'd0, 12'd0, 12'd0, 4'd0, 1'b1, 12'd0};
        vecs[6] = '{"op4",    64'hC000_0000_0000_0000, 0, 11'd0, 12'd0, 1'b0, 11'd0, 12'd0, 12'd0, 4'd0, 1'b1, 12'd0};
        vecs[7] = '{"op6",    64'hE000_0000_0000_0001, 0, 11'd0, 12'd0, 1'b0, 11'd0, 12'd0, 12'd0, 4'd0, 1'b1, 12'd0};
        vecs[8] = '{"op7",    64'hF000_0000_0000_0000, 0, 11'd0, 12'd0, 1'b0, 11'd0, 12'd0, 12'd0, 4'd0, 1'b1, 12'd0};

        for (int i = 0; i < 4096; i++) mem[i] = HALT_W;

        // Reset state
        rst = 1'b1; start = 1'b0; layer_ready = 1'b1; input_ack = 1'b0;
        tick(); tick();
        check("reset_outputs",
              {mem_rd_en, mem_addr, layer_valid, x_offset, w_offset, output_layer,
               y_offset, x_length, y_length, act_mask, input_req, busy, illegal_op},
              64'd0);
        check("reset_halted", 64'(halted), 64'd0);
        check("reset_pc", 64'(pc), 64'd0);

        // Single-word programs from the table
        for (int v = 0; v < 9; v++) begin
            mem[0] = vecs[v].word;
            mem[1] = HALT_W;
            do_reset();
            layer_ready = 1'b1;
            pulse_start(s);
            run_until_halted(vecs[v].name, 30);
            check({vecs[v].name, "_handshakes"}, 64'(hs_cyc_q.size()), 64'(vecs[v].exp_hs));
            check({vecs[v].name, "_illegal"}, 64'(illegal_op), 64'(vecs[v].exp_ill));
            check({vecs[v].name, "_halted"}, 64'(halted), 64'd1);
            check({vecs[v].name, "_pc"}, 64'(pc), 64'(vecs[v].exp_pc));
            if (vecs[v].exp_hs == 1)
                check({vecs[v].name, "_fields"}, 64'(hs_fields),
                      64'({vecs[v].x, vecs[v].w, vecs[v].ol, vecs[v].y,
                           vecs[v].xl, vecs[v].yl, vecs[v].am}));
        end

        // Latency of first layer with ready held high
        mem[0] = 64'h0051_0080_7310_0802;
        mem[1] = HALT_W;
        do_reset();
        layer_ready = 1'b1;
        pulse_start(s);
        run_until_halted("latency", 30);
        check("lat_first_fetch_cyc", 64'(fetch_cyc_q[0] - s), 64'd1);
        check("lat_handshake_cyc", 64'(hs_cyc_q[0] - s), 64'd3);
        check("lat_valid_cycles", 64'(lv_cnt), 64'd1);
        check("lat_second_fetch_cyc", 64'(fetch_cyc_q[1] - s), 64'd4);
        check("lat_fetch_count", 64'(fetch_addr_q.size()), 64'd2);
        check("lat_fetch_addr1", 64'(fetch_addr_q[1]), 64'd1);
        check("lat_busy_after_halt", 64'(busy), 64'd0);

        // Backpressure: ten stalled cycles, then release
        mem[0] = 64'h0010_0200_3004_0056;
        do_reset();
        layer_ready = 1'b0;
        pulse_start(s);
        for (int i = 0; i < 10 && !layer_valid; i++) tick();
        check("bp_valid_seen", 64'(layer_valid), 64'd1);
        held = {x_offset, w_offset, output_layer, y_offset, x_length, y_length, act_mask};
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (!layer_valid || mem_rd_en ||
                {x_offset, w_offset, output_layer, y_offset, x_length, y_length, act_mask} != held)
                bad++;
            tick();
        end
        check("bp_stable_cycles_bad", 64'(bad), 64'd0);
        layer_ready = 1'b1;
        tick();
        check("bp_valid_dropped", 64'(layer_valid), 64'd0);
        run_until_halted("bp", 30);
        check("bp_handshakes", 64'(hs_cyc_q.size()), 64'd1);
        check("bp_valid_cycles", 64'(lv_cnt), 64'd11);
        check("bp_fields", 64'(hs_fields), 64'h0010_0200_3004_0056);
        check("bp_fetch_count", 64'(fetch_addr_q.size()), 64'd2);

        // INPUT with delayed ack; stray ack while fetching is ignored
        mem[0] = 64'h9000_0000_0000_0000;
        mem[1] = HALT_W;
        do_reset();
        pulse_start(s);
        input_ack = 1'b1;
        tick();
        input_ack = 1'b0;
        for (int i = 0; i < 10 && !input_req; i++) tick();
        check("in_req_seen", 64'(input_req), 64'd1);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (!input_req || mem_rd_en) bad++;
            tick();
        end
        check("in_req_hold_bad", 64'(bad), 64'd0);
        input_ack = 1'b1;
        start = 1'b1;
        tick();
        input_ack = 1'b0;
        start = 1'b0;
        check("in_fetch_after_ack", 64'({mem_rd_en, mem_addr}), 64'({1'b1, 12'd1}));
        check("in_req_dropped", 64'(input_req), 64'd0);
        run_until_halted("input", 30);
        check("in_halted_pc", 64'(pc), 64'd1);
        check("in_fetch_count", 64'(fetch_addr_q.size()), 64'd2);

        // JUMP to 4095, layer there, pc wraps to 0 forever
        mem[0]    = 64'hBFFF_0000_0000_0000;
        mem[4095] = 64'h7FFF_FF7F_FFFF_FFFF;
        do_reset();
        layer_ready = 1'b1;
        pulse_start(s);
        repeat (30) tick();
        exp_addr = '{0, 4095, 0, 4095, 0};
        check("jmp_fetch_count_ge5", 64'(fetch_addr_q.size() >= 5), 64'd1);
        for (int i = 0; i < 5; i++)
            check($sformatf("jmp_addr%0d", i), 64'(fetch_addr_q[i]), 64'(exp_addr[i]));
        check("jmp_busy", 64'({busy, halted}), 64'({1'b1, 1'b0}));
        check("jmp_handshakes_ge2", 64'(hs_cyc_q.size() >= 2), 64'd1);
        layer_ready = 1'b0;
        for (int i = 0; i < 10 && !layer_valid; i++) tick();
        check("jmp_stall_valid", 64'(layer_valid), 64'd1);
        rst = 1'b1;
        tick();
        check("rst_mid_issue_outputs",
              {mem_rd_en, mem_addr, layer_valid, x_offset, w_offset, output_layer,
               y_offset, x_length, y_length, act_mask, input_req, busy, illegal_op},
              64'd0);
        check("rst_mid_issue_pc_halt", 64'({pc, halted}), 64'd0);
        rst = 1'b0;
        mem[4095] = HALT_W;

        // Illegal opcode 5, then restart clears the flag
        mem[0] = 64'hD000_0000_0000_0000;
        do_reset();
        pulse_start(s);
        run_until_halted("illegal", 30);
        check("ill_flag", 64'({illegal_op, halted}), 64'({1'b1, 1'b1}));
        clear_mon();
        pulse_start(s);
        check("ill_cleared", 64'(illegal_op), 64'd0);
        check("ill_refetch", 64'({mem_rd_en, mem_addr}), 64'({1'b1, 12'd0}));

`ifdef SEQ_PERF_CNT_EN
        mem[0] = 64'h0051_0080_7310_0802;
        mem[1] = 64'h7FFF_FF7F_FFFF_FFFF;
        mem[2] = 64'h0010_0200_3004_0056;
        mem[3] = HALT_W;
        do_reset();
        layer_ready = 1'b1;
        pulse_start(s);
        run_until_halted("perf", 40);
        check("perf_layer_count", 64'(layer_count), 64'd3);
        check("perf_busy_cycles", 64'(busy_cycles), 64'd12);
        check("perf_busy_vs_monitor", 64'(busy_cycles), 64'(busy_cnt));
        pulse_start(s);
        check("perf_clear_on_start", 64'({layer_count, busy_cycles}), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
